// File: rtl/mix_columns_seq_pkg.sv
// Shared widths, sequencer state encodings and GF(2^8) helpers for the
// MixColumns sequencer.
package mix_columns_seq_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Multiply by x in GF(2^8) with the AES polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_pre32.sv
// Column pre-step that turns a following forward MixColumns into
// InvMixColumns. Compiled only when INV_MIX_EN is defined.
`ifdef INV_MIX_EN
module inv_mix_pre32
  import mix_columns_seq_pkg::*;
(
  input  logic [AES_COL_W-1:0] col,
  output logic [AES_COL_W-1:0] pre
);

  logic [7:0] x [4];
  logic [7:0] t02;
  logic [7:0] t13;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign x[gi] = col[AES_COL_W-1-8*gi -: 8];
    end
  endgenerate

  // 4*(x0^x2) and 4*(x1^x3) are shared between the row pairs.
  assign t02 = xtime(xtime(x[0] ^ x[2]));
  assign t13 = xtime(xtime(x[1] ^ x[3]));

  assign pre = {x[0] ^ t02, x[1] ^ t13, x[2] ^ t02, x[3] ^ t13};

endmodule
`endif

// File: rtl/mixCol32.sv
// Combinational forward MixColumns on one 32-bit column (MSB byte = row 0).
module mixCol32
  import mix_columns_seq_pkg::*;
(
  input  logic [AES_COL_W-1:0] col,
  output logic [AES_COL_W-1:0] mixed
);

  logic [7:0] a  [4];
  logic [7:0] a2 [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign a[gi]  = col[AES_COL_W-1-8*gi -: 8];
      assign a2[gi] = xtime(a[gi]);
    end
    // Row r: 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign mixed[AES_COL_W-1-8*gi -: 8] = a2[gi] ^ a2[(gi+1)%4] ^ a[(gi+1)%4]
                                          ^ a[(gi+2)%4] ^ a[(gi+3)%4];
    end
  endgenerate

endmodule

// File: rtl/mix_columns_seq.sv
// MixColumns sequencer: one state in, four columns through a shared mixer,
// one state out. Define INV_MIX_EN to add the in_inv port and InvMixColumns.
module mix_columns_seq
  import mix_columns_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
`ifdef INV_MIX_EN
  input  logic                   in_inv,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  seq_state_e             state_reg, state_next;
  logic [1:0]             cnt_reg;
  logic [AES_STATE_W-1:0] data_reg;
  logic                   accept;
  logic [AES_COL_W-1:0]   cols [4];
  logic [AES_COL_W-1:0]   col_sel;
  logic [AES_COL_W-1:0]   mix_in;
  logic [AES_COL_W-1:0]   mix_out;
  logic [3:0]             col_we;

  // FSM next-state and outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_reg == 2'd3) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg  <= 2'd0;
        data_reg <= in_state;
      end else if (busy) begin
        cnt_reg <= cnt_reg + 2'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [AES_COL_W-1:0] col_reg;

      assign cols[gi]   = data_reg[AES_STATE_W-1-AES_COL_W*gi -: AES_COL_W];
      assign col_we[gi] = busy & (cnt_reg == 2'(gi));
      assign out_state[AES_STATE_W-1-AES_COL_W*gi -: AES_COL_W] = col_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)              col_reg <= '0;
        else if (col_we[gi])  col_reg <= mix_out;
      end
    end
  endgenerate

  assign col_sel = cols[cnt_reg];

`ifdef INV_MIX_EN
  logic                 inv_reg;
  logic [AES_COL_W-1:0] col_pre;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         inv_reg <= 1'b0;
    else if (accept) inv_reg <= in_inv;
  end

  inv_mix_pre32 u_pre (
    .col (col_sel),
    .pre (col_pre)
  );

  assign mix_in = inv_reg ? col_pre : col_sel;
`else
  assign mix_in = col_sel;
`endif

  mixCol32 u_mix (
    .col   (mix_in),
    .mixed (mix_out)
  );

endmodule
